// File: rtl/vga_vram_arbiter_if.sv
// Host-side port of the VGA video-RAM arbiter.
// The drawing logic (master) raises host_req with host_we/host_addr/host_wdata
// held stable and waits for the one-cycle host_ack pulse. host_rdata is valid
// while host_ack is high. host_blank_only restricts grants to blanking time.
//   master : drives req/we/addr/wdata/blank_only, receives ack/rdata
//   slave  : the arbiter side of the same signals
interface vga_vram_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 3
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_blank_only;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata, host_blank_only,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, host_blank_only,
    output host_ack, host_rdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Shares one single-port synchronous video RAM between the VGA display fetch
// and a host (drawing) port, registers the pixel colour and delays the syncs
// so colour and sync leave the block aligned.
// Ports:
//   CLK, RESET                 system clock (2x pixel rate), sync active-high reset
//   p_tick, pixel_X, pixel_Y   pixel enable and counters from the sync generator
//   sincro_horiz/vert          syncs from the sync generator
//   host                       host req/ack port (vga_vram_arbiter_if.slave)
//   ram_addr/we/wdata/rdata    framebuffer RAM port, read latency 1 cycle
//   rgb, hsync_out, vsync_out  registered VGA pin outputs
//   frame_start, frame_cnt     frame-origin pulse and 8-bit frame counter
module vga_vram_arbiter #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 3
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     p_tick,
  input  logic [9:0]               pixel_X,
  input  logic [9:0]               pixel_Y,
  input  logic                     sincro_horiz,
  input  logic                     sincro_vert,
  vga_vram_arbiter_if.slave        host,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic                     ram_we,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic [DATA_W-1:0]        rgb,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     frame_start,
  output logic [7:0]               frame_cnt
);

  localparam int FB_W    = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_H    = V_ACTIVE >> SCALE_SHIFT;
  localparam int FB_SIZE = FB_W * FB_H;

  localparam logic [ADDR_W-1:0] FB_SIZE_A  = ADDR_W'(FB_SIZE);
  localparam logic [ADDR_W-1:0] FB_W_A     = ADDR_W'(FB_W);
  localparam logic [9:0]        H_ACTIVE_P = 10'(H_ACTIVE);
  localparam logic [9:0]        V_ACTIVE_P = 10'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              grant_s;
  logic              active_s;
  logic              disp_slot_s;
  logic              host_elig_s;
  logic              in_range_s;
  logic              in_range_r;
  logic              disp_prev_r;
  logic [ADDR_W-1:0] row_s;
  logic [ADDR_W-1:0] col_s;
  logic [ADDR_W-1:0] disp_addr_s;
  logic [DATA_W-1:0] host_rdata_r;
  logic [DATA_W-1:0] rgb_r;
  logic              hsync_r;
  logic              vsync_r;
  logic [7:0]        frame_cnt_r;

  assign active_s    = (pixel_X < H_ACTIVE_P) && (pixel_Y < V_ACTIVE_P);
  // The display reads in the p_tick=0 half of each pixel; the p_tick=1 half is
  // always free, which bounds the host wait to one cycle outside tear-free mode.
  assign disp_slot_s = !p_tick && active_s;
  assign host_elig_s = !disp_slot_s && (!host.host_blank_only || !active_s);
  assign in_range_s  = (host.host_addr < FB_SIZE_A);

  assign row_s       = ADDR_W'(pixel_Y >> SCALE_SHIFT);
  assign col_s       = ADDR_W'(pixel_X >> SCALE_SHIFT);
  assign disp_addr_s = (row_s * FB_W_A) + col_s;

  // Host FSM next-state and grant decode
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (host.host_req && host_elig_s) begin
          grant_s     = 1'b1;
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA:    state_nxt_s = ACK;
      ACK:     state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // RAM port mux: display slot, host grant, or parked at zero
  always_comb begin
    ram_addr  = {ADDR_W{1'b0}};
    ram_we    = 1'b0;
    ram_wdata = {DATA_W{1'b0}};
    if (disp_slot_s) begin
      ram_addr = disp_addr_s;
    end else if (grant_s) begin
      ram_addr  = host.host_addr;
      ram_we    = host.host_we && in_range_s;
      ram_wdata = host.host_wdata;
    end else begin
      ram_addr  = {ADDR_W{1'b0}};
      ram_we    = 1'b0;
      ram_wdata = {DATA_W{1'b0}};
    end
  end

  // Host FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Host read path: range decision taken at grant, data captured one cycle later
  always_ff @(posedge CLK) begin
    if (RESET) begin
      in_range_r   <= 1'b0;
      host_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (grant_s) begin
        in_range_r <= in_range_s;
      end
      if (state_r == DATA) begin
        host_rdata_r <= in_range_r ? ram_rdata : {DATA_W{1'b0}};
      end
    end
  end

  assign host.host_ack   = (state_r == ACK);
  assign host.host_rdata = host_rdata_r;

  // Display pipeline: colour and syncs advance together on the pixel enable
  always_ff @(posedge CLK) begin
    if (RESET) begin
      disp_prev_r <= 1'b0;
      rgb_r       <= {DATA_W{1'b0}};
      hsync_r     <= 1'b1;
      vsync_r     <= 1'b1;
    end else begin
      disp_prev_r <= disp_slot_s;
      if (p_tick) begin
        rgb_r   <= disp_prev_r ? ram_rdata : {DATA_W{1'b0}};
        hsync_r <= sincro_horiz;
        vsync_r <= sincro_vert;
      end
    end
  end

  assign rgb       = rgb_r;
  assign hsync_out = hsync_r;
  assign vsync_out = vsync_r;

  assign frame_start = p_tick && (pixel_X == 10'd0) && (pixel_Y == 10'd0);

  // Frame counter, wraps naturally at 8 bits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      frame_cnt_r <= 8'd0;
    end else if (frame_start) begin
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_r;

endmodule
